// File: rtl/serializer.sv
// ---------------------------------------------------------------------------
// serializer
//
// Streams one wide parallel word out as a sequence of narrow words. Slice 0
// (the least-significant OUTPUT_SIZE bits) comes out first. Each slice k of
// the wide word is the k-th narrow word, so this block is the inverse of the
// input deserializer. Valid/ready handshakes are used on both sides. A new
// frame is accepted in the same cycle that the last slice of the current
// frame is consumed, so back-to-back frames stream out with no bubble.
//
// Parameters:
//   INPUT_SIZE  - width of the parallel input word (default 256)
//   OUTPUT_SIZE - width of each serial output word (default 16);
//                 INPUT_SIZE must be a multiple of OUTPUT_SIZE, ratio >= 2
//
// Ports:
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   in_valid  - 'in' carries a frame
//   in_ready  - the block accepts a frame this cycle
//   in        - parallel frame
//   out_valid - 'out' carries a slice
//   out_ready - downstream consumes 'out' this cycle
//   out       - current slice
//   out_last  - 'out' is the final slice of the frame
// ---------------------------------------------------------------------------
module serializer #(
    parameter int INPUT_SIZE  = 256,
    parameter int OUTPUT_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_SIZE-1:0]  in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUTPUT_SIZE-1:0] out,
    output logic                   out_last
);

    localparam int NUM_WORDS  = INPUT_SIZE / OUTPUT_SIZE;
    localparam int INDEX_SIZE = $clog2(NUM_WORDS);
    localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(NUM_WORDS - 1);

    // The state encoding is exactly the registered out_valid flag.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [INPUT_SIZE-1:0]   frame_reg, frame_next;
    logic [INDEX_SIZE-1:0]   idx_reg, idx_next;

    logic                    is_last;
    logic                    in_xfer;
    logic [OUTPUT_SIZE-1:0]  slices [NUM_WORDS];

    // Split the held frame into slices. The output is a mux over registers,
    // so there is no combinational path from 'in' to 'out'.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slice
            assign slices[gi] = frame_reg[gi*OUTPUT_SIZE +: OUTPUT_SIZE];
        end
    endgenerate

    assign out_valid = (state_reg == SEND);
    assign is_last   = (idx_reg == LAST_IDX);
    assign out_last  = out_valid & is_last;
    assign out       = slices[idx_reg];

    // The block is ready when it is empty, or when the last slice leaves in
    // this very cycle. This is the only path from an input to an output.
    assign in_ready  = ~out_valid | (out_ready & out_last);
    assign in_xfer   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            frame_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            frame_reg <= frame_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        idx_next   = idx_reg;

        case (state_reg)
            IDLE: begin
                // 'in' is sampled only on a transfer, so X on an idle bus
                // never reaches the frame register.
                if (in_xfer) begin
                    frame_next = in;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!is_last) begin
                        idx_next = idx_reg + INDEX_SIZE'(1);
                    end else if (in_xfer) begin
                        // Zero-bubble hand-over to the next frame.
                        frame_next = in;
                        idx_next   = '0;
                    end else begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Converts one wide parallel word into a stream of narrow words, emitted least-significant slice first.
- Typical use: taking eight 32-bit FFT results (256 bits) and streaming them out as 16-bit words.
- Sits on the output side of the FFT core. It is the exact inverse of the team's input deserializer: slice k of the wide word appears as the k-th narrow word.
- Valid/ready handshake on both sides. Supports full throughput, including back-to-back frames with no bubble.

Parameters:
- INPUT_SIZE, default 256: width of the parallel input word.
- OUTPUT_SIZE, default 16: width of each serial output word. INPUT_SIZE must be an integer multiple of OUTPUT_SIZE, with ratio ≥ 2.
- NUM_WORDS (localparam), INPUT_SIZE/OUTPUT_SIZE: number of output words per frame.
- INDEX_SIZE (localparam), $clog2(NUM_WORDS): width of the slice counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: the wide word on in is valid.
- in_ready, output, 1: the block accepts in this cycle.
- in, input, INPUT_SIZE: parallel frame.
- out_valid, output, 1: out holds a valid slice.
- out_ready, input, 1: the downstream block consumes out this cycle.
- out, output, OUTPUT_SIZE: current slice.
- out_last, output, 1: high with the final slice (index NUM_WORDS-1) of a frame.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Storage: frame register buf[INPUT_SIZE-1:0], slice index idx[INDEX_SIZE-1:0], registered out_valid.
- Reset values: out_valid=0, idx=0, buf=0. Consequently out=0 and out_last=0. in_ready=1 after reset.
- Assertion of reset_n low mid-frame discards the frame immediately. No partial slices appear after release.
- Transfer definitions: input transfer = in_valid & in_ready at a rising edge; output transfer = out_valid & out_ready at a rising edge.
- out = buf[idx*OUTPUT_SIZE +: OUTPUT_SIZE]. This is a mux from registers, with no combinational path from in.
- out_last = out_valid & (idx == NUM_WORDS-1).
- in_ready = !out_valid | (out_ready & out_last). This is combinational from out_ready; it is the only combinational input-to-output path.
- State machine, two states encoded by out_valid:
  - IDLE (out_valid=0): on input transfer, load buf<=in, set idx<=0 and out_valid<=1. Otherwise hold.
  - SEND (out_valid=1), no output transfer: hold buf, idx, out. out and out_last must stay stable until accepted; stall length is unbounded.
  - SEND, output transfer with idx<NUM_WORDS-1: idx<=idx+1.
  - SEND, output transfer on the last slice with a simultaneous input transfer: load buf<=in, idx<=0, out_valid stays 1. Slice 0 of the new frame is presented the next cycle (zero-bubble).
  - SEND, output transfer on the last slice with no input transfer: out_valid<=0, idx<=0, return to IDLE.
- Latency: slice 0 is visible on out one cycle after the input transfer.
- Throughput: one slice per cycle while out_ready=1. A sustained input stream yields out_valid continuously high.
- in_valid asserted while in_ready=0 has no effect. The upstream block must hold in stable until accepted.
- X on in while in_valid=0 must not propagate into buf.
- out_ready toggling mid-frame only pauses the index. Slices are never skipped or duplicated.

Test Plan:
- Reset then single frame: in=256'h000F_000E_…_0001_0000 (slice k = k), out_ready=1 -> out = 0,1,…,15 on 16 consecutive cycles; out_last only with value 15; out_valid low afterwards; in_ready low during cycles 1-15 of the frame.
- Back-to-back: frames A (slices 16'hA000+k) and B (16'hB000+k), in_valid held high -> 32 consecutive valid cycles; B is accepted in the same cycle A's slice 15 transfers; slice 16'hB000 follows 16'hA00F directly with no gap.
- Backpressure: out_ready pattern 1,0,0,1,0,1… over one frame -> out, out_valid and out_last stay stable during stalls; all 16 slices are delivered in order, none duplicated.
- Input blocked: second frame offered with in_valid=1 at slice 5 of the first frame -> in_ready=0 until slice 15 transfers; the second frame is not corrupted and is not loaded early.
- Reset mid-frame: reset_n pulsed low asynchronously (between edges) after slice 7 -> out_valid drops to 0 immediately; after release, in_ready=1, and a new frame starts at slice 0.
- Round trip: serializer output fed into the deserializer (input_valid=out_valid&out_ready) over 100 random frames with random out_ready -> deserializer out equals the original 256-bit frames, with output_valid pulsing once per frame.
